// File: rtl/jk_ff.sv
// Two-flip-flop JK controller.
// A purely combinational evaluator maps an externally supplied present state
// (A, B) plus inputs (x, y) to next state and output, for state-table lookup.
// A registered copy of the same machine (qa, qb) runs on clk_sys-domain clk,
// with a synchronous preset from A, B that takes priority over the JK update.
//
// Registered state table:
//   qa qb | meaning
//   0  0  | reset / idle state
//   0  1  | state B only set
//   1  0  | state A only set
//   1  1  | both set
module jk_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic y,
  input  logic A,
  input  logic B,
  input  logic ld,
  output logic Aout,
  output logic Bout,
  output logic z,
  output logic qa,
  output logic qb,
  output logic zq
);

  // JK characteristic: hold, clear, set or toggle selected by (j, k).
  function automatic logic jk_next(input logic j, input logic k, input logic cur);
    return (j & ~cur) | (~k & cur);
  endfunction

  logic ja_c, ka_c, jb_c, kb_c;
  logic ja_q, ka_q, jb_q, kb_q;
  logic qa_next, qb_next;

  // Table-lookup path: next state and output from the supplied present state.
  always_comb begin
    ja_c = (B & x) | (~B & ~y);
    ka_c = ~B & x & ~y;
    jb_c = ~A & x;
    kb_c = A | (x & ~y);
    Aout = jk_next(ja_c, ka_c, A);
    Bout = jk_next(jb_c, kb_c, B);
    z    = ~x & ~y & (A | B);
  end

  // Running machine: JK next state from the registered state, preset wins.
  always_comb begin
    ja_q    = (qb & x) | (~qb & ~y);
    ka_q    = ~qb & x & ~y;
    jb_q    = ~qa & x;
    kb_q    = qa | (x & ~y);
    qa_next = jk_next(ja_q, ka_q, qa);
    qb_next = jk_next(jb_q, kb_q, qb);
    if (ld) begin
      qa_next = A;
      qb_next = B;
    end
  end

  // State register with immediate clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa <= 1'b0;
      qb <= 1'b0;
    end else begin
      qa <= qa_next;
      qb <= qb_next;
    end
  end

  // Mealy output of the running machine; follows x, y between edges.
  always_comb begin
    zq = ~x & ~y & (qa | qb);
  end

endmodule

// File: tb/tb_jk_ff.sv
// Self-checking bench for jk_ff: directed scenarios plus randomized run
// against a behavioural model built from the flip-flop input equations.
module tb_jk_ff;

  logic clk = 1'b0;
  logic rst_n, x, y, A, B, ld;
  logic Aout, Bout, z, qa, qb, zq;

  int vectors = 0;
  int errors  = 0;

  // Model state for the registered machine.
  logic m_qa, m_qb;

  jk_ff dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .A(A), .B(B), .ld(ld),
    .Aout(Aout), .Bout(Bout), .z(z), .qa(qa), .qb(qb), .zq(zq)
  );

  always #5 clk = ~clk;

  // Reference: apply the JK rule case by case, returns {next_p, next_q, z}.
  function automatic logic [2:0] model(input logic xi, input logic yi,
                                       input logic p, input logic q);
    int ja, ka, jb, kb;
    logic np, nq, zo;
    ja = (q * xi) + ((1 - q) * (1 - yi));
    ka = (1 - q) * xi * (1 - yi);
    jb = (1 - p) * xi;
    kb = p + xi * (1 - yi);
    if (ja > 1) ja = 1;
    if (kb > 1) kb = 1;
    case ({ja[0], ka[0]})
      2'b00: np = p;
      2'b01: np = 1'b0;
      2'b10: np = 1'b1;
      default: np = ~p;
    endcase
    case ({jb[0], kb[0]})
      2'b00: nq = q;
      2'b01: nq = 1'b0;
      2'b10: nq = 1'b1;
      default: nq = ~q;
    endcase
    zo = (xi == 1'b0 && yi == 1'b0 && (p || q));
    return {np, nq, zo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic a_v, input logic b_v);
    @(negedge clk);
    ld = 1'b1; A = a_v; B = b_v;
    tick();
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({qa, qb} !== 2'b00) begin
      errors++;
      $display("FAIL reset_state qa,qb got %b%b want 00", qa, qb);
    end
    vectors++;
    if (zq !== 1'b0) begin
      errors++;
      $display("FAIL reset_zq got %b want 0", zq);
    end
  endtask

  task automatic test_comb_sweep();
    logic [2:0] exp;
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      {x, y, A, B} = v;
      #100;
      exp = model(v[3], v[2], v[1], v[0]);
      vectors++;
      if ({Aout, Bout, z} !== exp) begin
        errors++;
        $display("FAIL comb_sweep xyAB=%b got %b%b%b want %b", v, Aout, Bout, z, exp);
      end
    end
  endtask

  task automatic test_table_rows();
    logic [3:0] in_v [6]  = '{4'b0000, 4'b0011, 4'b0101, 4'b1000, 4'b1011, 4'b1110};
    logic [2:0] out_v [6] = '{3'b100,  3'b101,  3'b010,  3'b110,  3'b100,  3'b100};
    for (int i = 0; i < 6; i++) begin
      {x, y, A, B} = in_v[i];
      #10;
      vectors++;
      if ({Aout, Bout, z} !== out_v[i]) begin
        errors++;
        $display("FAIL table_row xyAB=%b got %b%b%b want %b",
                 in_v[i], Aout, Bout, z, out_v[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    x = 1'b0; y = 1'b1;
    do_load(1'b1, 1'b1);
    vectors++;
    if ({qa, qb} !== 2'b11) begin
      errors++;
      $display("FAIL async_preload got %b%b want 11", qa, qb);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({qa, qb} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset got %b%b want 00", qa, qb);
    end
    x = 1'b1; y = 1'b0;
    tick();
    vectors++;
    if ({qa, qb} !== 2'b00) begin
      errors++;
      $display("FAIL reset_held got %b%b want 00", qa, qb);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_registered_run();
    logic [1:0] seq [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    x = 1'b1; y = 1'b0; ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      vectors++;
      if ({qa, qb} !== seq[i] || zq !== 1'b0) begin
        errors++;
        $display("FAIL registered_run step %0d got %b%b zq=%b want %b zq=0",
                 i, qa, qb, zq, seq[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    @(negedge clk);
    ld = 1'b1; A = 1'b0; B = 1'b1; x = 1'b1; y = 1'b0;
    tick();
    vectors++;
    if ({qa, qb} !== 2'b01) begin
      errors++;
      $display("FAIL load_priority got %b%b want 01", qa, qb);
    end
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic test_mealy();
    do_load(1'b1, 1'b1);
    x = 1'b0; y = 1'b0;
    #1;
    vectors++;
    if (zq !== 1'b1) begin
      errors++;
      $display("FAIL mealy_high got %b want 1", zq);
    end
    y = 1'b1;
    #1;
    vectors++;
    if (zq !== 1'b0 || {qa, qb} !== 2'b11) begin
      errors++;
      $display("FAIL mealy_low got zq=%b q=%b%b want zq=0 q=11", zq, qa, qb);
    end
  endtask

  task automatic test_hold();
    do_load(1'b0, 1'b1);
    x = 1'b0; y = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({qa, qb} !== 2'b01) begin
        errors++;
        $display("FAIL hold edge %0d got %b%b want 01", i, qa, qb);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] c, r;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_qa = 1'b0; m_qb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      x  = 1'($urandom_range(0, 1));
      y  = 1'($urandom_range(0, 1));
      A  = 1'($urandom_range(0, 1));
      B  = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        m_qa = 1'b0; m_qb = 1'b0;
        vectors++;
        if ({qa, qb} !== 2'b00) begin
          errors++;
          $display("FAIL rand_reset cycle %0d got %b%b want 00", i, qa, qb);
        end
        rst_n = 1'b1;
      end
      #1;
      c = model(x, y, A, B);
      vectors++;
      if ({Aout, Bout, z} !== c) begin
        errors++;
        $display("FAIL rand_comb cycle %0d got %b%b%b want %b", i, Aout, Bout, z, c);
      end
      r = model(x, y, m_qa, m_qb);
      if (ld) begin
        m_qa = A; m_qb = B;
      end else begin
        m_qa = r[2]; m_qb = r[1];
      end
      tick();
      r = model(x, y, m_qa, m_qb);
      vectors++;
      if ({qa, qb, zq} !== {m_qa, m_qb, r[0]}) begin
        errors++;
        $display("FAIL rand_reg cycle %0d got q=%b%b zq=%b want q=%b%b zq=%b",
                 i, qa, qb, zq, m_qa, m_qb, r[0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; x = 1'b0; y = 1'b0; A = 1'b0; B = 1'b0; ld = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    test_comb_sweep();
    test_table_rows();
    test_async_reset();
    test_registered_run();
    test_load_priority();
    test_mealy();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/jk_ff.md
Name: jk_ff

Overview:
- Two-flip-flop JK sequential controller with inputs x, y and one output z.
- Provides a combinational next-state/output evaluator driven by an externally supplied present state on A, B. This path is used for state-table characterization.
- Also provides an internal registered copy of the same machine, qa/qb, clocked by clk.
- Leaf block with no sub-modules; sits inside control logic that needs both table lookup and a running state.

Parameters:
- none. The machine equations are fixed.

Ports:
- clk    input   1  system clock; all registers update on the rising edge
- rst_n  input   1  asynchronous, active-low reset
- x      input   1  machine input x
- y      input   1  machine input y
- A      input   1  present state A for the combinational path; preset value for qa on load
- B      input   1  present state B for the combinational path; preset value for qb on load
- ld     input   1  synchronous preset of the registered state from A, B
- Aout   output  1  combinational next state of A, computed from (x, y, A, B)
- Bout   output  1  combinational next state of B, computed from (x, y, A, B)
- z      output  1  combinational output, computed from (x, y, A, B)
- qa     output  1  registered state A
- qb     output  1  registered state B
- zq     output  1  output z evaluated on (x, y, qa, qb), combinational (Mealy)

Behaviour:
- Flip-flop input equations (P, Q denote the present state):
  - JA = Q·x + Q'·y'
  - KA = Q'·x·y'
  - JB = P'·x
  - KB = P + x·y'
- JK characteristic:
  - next = J·cur' + K'·cur
  - J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
- Output equation: z = x'·y'·(P + Q).
- Combinational path (P=A, Q=B):
  - Aout, Bout and z depend only on x, y, A, B.
  - Independent of clk, rst_n and ld.
  - Zero latency; no registers in this path.
- Registered path (P=qa, Q=qb):
  - rst_n low: qa=0 and qb=0 immediately, regardless of clk. Held while rst_n is low.
  - zq follows from the register values (0 during reset unless the equations yield otherwise; with qa=qb=0, zq=0).
  - Rising clk edge with rst_n high and ld=1: qa<=A, qb<=B. Load has priority over JK update.
  - Rising clk edge with rst_n high and ld=0: qa and qb take the JK next state computed from (x, y, qa, qb).
  - rst_n deasserted: first update occurs on the next rising clk edge.
  - zq = x'·y'·(qa + qb), combinational. It may change between edges when x or y change.
- Reset values: qa=0, qb=0. Aout, Bout, z and zq are not registered and have no reset value of their own.
- No X propagation is permitted from known inputs; every output is fully defined for all 16 (x, y, P, Q) combinations.

Test Plan:
- Exhaustive combinational sweep of the 16 combinations of (x, y, A, B), in order x, y, A, B with x as MSB, 100 time units apart. Required results include:
  - 0000 -> Aout=1, Bout=0, z=0
  - 0011 -> Aout=1, Bout=0, z=1
  - 0101 -> Aout=0, Bout=1, z=0
  - 1000 -> Aout=1, Bout=1, z=0
  - 1011 -> Aout=1, Bout=0, z=0
  - 1110 -> Aout=1, Bout=0, z=0
  - Check every row against the equations.
- Async reset: set qa=qb=1 by load, then pull rst_n low between clock edges -> qa=qb=0 immediately with no clk edge required.
- Registered run, after reset with x=1, y=0, ld=0 -> (qa,qb) sequence over 3 edges is 00 -> 11 -> 10 -> 00; zq=0 throughout.
- Load priority: ld=1, A=0, B=1, x=1, y=0 at an edge -> qa=0, qb=1. JK values are ignored.
- Mealy output: load qa=1, qb=1, then hold x=0, y=0 -> zq=1. Change y to 1 without a clock edge -> zq=0.
- Hold case: load qa=0, qb=1, set x=0, y=1, clock 3 edges -> state remains 01.
